// File: rtl/game_pkg.sv
// Shared port ids and read-return tag for the player-number RAM arbiter.
// Imported by the arbiter top and its bench.
package game_pkg;

  localparam int TAG_W = 2;

  typedef logic [TAG_W-1:0] port_id_t;

  localparam port_id_t PORT_ENTRY = 2'd0;
  localparam port_id_t PORT_LOGIC = 2'd1;
  localparam port_id_t PORT_DISP  = 2'd2;

  typedef struct packed {
    logic     vld;
    port_id_t id;
  } rtag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; rr_last=1 means b was granted last.
// Reset leaves b as "last", so a is favoured first.
module rr_arb2 (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic rr_last;

  assign gnt_a = en & req_a & (~req_b | rr_last);
  assign gnt_b = en & req_b & (~req_a | ~rr_last);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_last <= 1'b1;
    end else if (gnt_a) begin
      rr_last <= 1'b0;
    end else if (gnt_b) begin
      rr_last <= 1'b1;
    end
  end

endmodule

// File: rtl/game_mem_arbiter.sv
// Shares the single-port player-number RAM between entry, game logic
// and display; one access per cycle, tagged read return next cycle.
module game_mem_arbiter
  import game_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  game_active,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  req2,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  we2,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [DATA_WIDTH-1:0] wdata2,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  gnt2,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  rvalid2,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  entry_reject
);

  logic                  elig0;
  logic                  en12;
  logic                  req1_ok;
  logic                  gnt_any;
  logic                  sel_we;
  port_id_t              sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  rtag_t                 tag_q;
  logic                  rej_q;
  logic                  rej_d;
  logic                  tag_live;

  assign elig0   = req0 & ~game_active;
  assign req1_ok = req1 & game_active;
  assign gnt0    = rstn & elig0;
  assign en12    = rstn & ~elig0;

  rr_arb2 u_rr (
    .clk   (clk),
    .rstn  (rstn),
    .en    (en12),
    .req_a (req1_ok),
    .req_b (req2),
    .gnt_a (gnt1),
    .gnt_b (gnt2)
  );

  assign gnt_any = gnt0 | gnt1 | gnt2;

  // Without a grant the bus replays the last granted address/data.
  always_comb begin
    sel_we    = 1'b0;
    sel_id    = PORT_ENTRY;
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    unique case (1'b1)
      gnt0: begin
        sel_we    = we0;
        sel_id    = PORT_ENTRY;
        sel_addr  = addr0;
        sel_wdata = wdata0;
      end
      gnt1: begin
        sel_we    = we1;
        sel_id    = PORT_LOGIC;
        sel_addr  = addr1;
        sel_wdata = wdata1;
      end
      gnt2: begin
        sel_we    = we2;
        sel_id    = PORT_DISP;
        sel_addr  = addr2;
        sel_wdata = wdata2;
      end
      default: ;
    endcase
  end

  assign mem_we    = sel_we;
  assign mem_addr  = rstn ? sel_addr : '0;
  assign mem_wdata = rstn ? sel_wdata : '0;

  // A reject can only arise while a game runs, so dropping game_active
  // is exactly the 1->0 edge that clears it.
  assign rej_d        = game_active & (rej_q | req0);
  assign entry_reject = rstn & rej_d;

  assign tag_live = rstn & tag_q.vld;
  assign rvalid0  = tag_live & (tag_q.id == PORT_ENTRY);
  assign rvalid1  = tag_live & (tag_q.id == PORT_LOGIC);
  assign rvalid2  = tag_live & (tag_q.id == PORT_DISP);
  assign rdata    = tag_live ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      rej_q   <= 1'b0;
    end else begin
      if (gnt_any) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      tag_q.vld <= gnt_any & ~sel_we;
      tag_q.id  <= sel_id;
      rej_q     <= rej_d;
    end
  end

endmodule
